wiper_sweep: RTL

//  Wiper-arm sequencer, downstream of the rain-sensing wiper controller.
//  - Consumes its registered off/slow/fast mode.
//  - Drives a one-hot arm position onto the LED bar, sweeping out and back.
//  - Always finishes a sweep and parks at position 0; never stops mid-glass.

---
 rtl/wiper_sweep.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/wiper_sweep.sv
// Wiper-arm sequencer: sweeps a one-hot arm position out and back at the slow or fast
// rate and always parks at position 0. Optional wash feature: define WIPER_WASH_EN.
module wiper_sweep #(
    parameter int NPOS        = 7,
    parameter int SLOW_DIV    = 4,
    parameter int FAST_DIV    = 1,
    parameter int DWELL_TICKS = 8,
    parameter int WASH_SWEEPS = 3
) (
    input  logic            clk_2,
    input  logic            reset_n,
    input  logic [1:0]      mode,
`ifdef WIPER_WASH_EN
    input  logic            wash,
`endif
    output logic [NPOS-1:0] led_arm,
    output logic            parked,
    output logic [7:0]      sweep_count
);

    localparam int              PW       = (NPOS > 2) ? $clog2(NPOS) : 1;
    localparam logic [PW-1:0]   POS_TOP  = PW'(NPOS - 1);
    localparam logic [PW-1:0]   POS_ONE  = PW'(1);
    localparam logic [PW-1:0]   POS_ZERO = PW'(0);
    localparam logic [7:0]      SLOW_M1  = 8'(SLOW_DIV - 1);
    localparam logic [7:0]      FAST_M1  = 8'(FAST_DIV - 1);
    localparam logic [7:0]      DWELL_M1 = 8'(DWELL_TICKS - 1);
    localparam logic [NPOS-1:0] LED_ONE  = NPOS'(1);

    localparam logic [1:0] EFF_OFF  = 2'd0;
    localparam logic [1:0] EFF_SLOW = 2'd1;
    localparam logic [1:0] EFF_FAST = 2'd2;

    typedef enum logic [1:0] {
        PARKED     = 2'd0,
        SWEEP_OUT  = 2'd1,
        SWEEP_BACK = 2'd2,
        DWELL      = 2'd3
    } state_t;

    state_t        state_r, state_s;
    logic [PW-1:0] pos_r, pos_s;
    logic [7:0]    div_r, div_s;
    logic [7:0]    dwell_r, dwell_s;
    logic [7:0]    count_r, count_s;
    logic          hold_fast_r, hold_fast_s;
    logic [1:0]    eff_s;
    logic [1:0]    done_eff_s;
    logic          rate_fast_s;
    logic          tick_s;
    logic          done_s;
    logic          wash_act_s;
    logic          wash_more_s;

`ifdef WIPER_WASH_EN
    logic [3:0] wash_left_r;

    assign wash_act_s  = (wash_left_r != 4'd0);
    assign wash_more_s = (wash_left_r > 4'd1);

    // Wash counter: a request (re)loads it, each completed sweep uses one up.
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            wash_left_r <= 4'd0;
        end else if (wash) begin
            wash_left_r <= 4'(WASH_SWEEPS);
        end else if (done_s && wash_act_s) begin
            wash_left_r <= wash_left_r - 4'd1;
        end else begin
            wash_left_r <= wash_left_r;
        end
    end
`else
    assign wash_act_s  = 1'b0;
    assign wash_more_s = 1'b0;
`endif

    // Effective rate now, and the rate that applies after a sweep completes
    // (the completing sweep has already consumed its wash credit).
    always_comb begin
        if (mode[1] || wash_act_s) begin
            eff_s = EFF_FAST;
        end else if (mode == 2'd1) begin
            eff_s = EFF_SLOW;
        end else begin
            eff_s = EFF_OFF;
        end
        if (mode[1] || wash_more_s) begin
            done_eff_s = EFF_FAST;
        end else if (mode == 2'd1) begin
            done_eff_s = EFF_SLOW;
        end else begin
            done_eff_s = EFF_OFF;
        end
        if (eff_s == EFF_OFF) begin
            rate_fast_s = hold_fast_r;
            hold_fast_s = hold_fast_r;
        end else begin
            rate_fast_s = (eff_s == EFF_FAST);
            hold_fast_s = (eff_s == EFF_FAST);
        end
        tick_s = (div_r >= (rate_fast_s ? FAST_M1 : SLOW_M1));
    end

    // State register.
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= PARKED;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and datapath next values.
    always_comb begin
        state_s = state_r;
        pos_s   = pos_r;
        div_s   = div_r;
        dwell_s = dwell_r;
        count_s = count_r;
        done_s  = 1'b0;
        case (state_r)
            PARKED: begin
                pos_s   = POS_ZERO;
                div_s   = 8'd0;
                dwell_s = 8'd0;
                if (eff_s != EFF_OFF) begin
                    state_s = SWEEP_OUT;
                end else begin
                    state_s = PARKED;
                end
            end
            SWEEP_OUT: begin
                if (tick_s) begin
                    div_s = 8'd0;
                    pos_s = pos_r + POS_ONE;
                    if (pos_s == POS_TOP) begin
                        state_s = SWEEP_BACK;
                    end else begin
                        state_s = SWEEP_OUT;
                    end
                end else begin
                    div_s = div_r + 8'd1;
                end
            end
            SWEEP_BACK: begin
                if (tick_s) begin
                    div_s = 8'd0;
                    pos_s = pos_r - POS_ONE;
                    if (pos_r == POS_ONE) begin
                        done_s  = 1'b1;
                        count_s = (count_r == 8'd255) ? count_r : count_r + 8'd1;
                        dwell_s = 8'd0;
                        case (done_eff_s)
                            EFF_OFF:  state_s = PARKED;
                            EFF_SLOW: state_s = DWELL;
                            default:  state_s = SWEEP_OUT;
                        endcase
                    end else begin
                        state_s = SWEEP_BACK;
                    end
                end else begin
                    div_s = div_r + 8'd1;
                end
            end
            DWELL: begin
                pos_s = POS_ZERO;
                div_s = 8'd0;
                if (eff_s == EFF_FAST) begin
                    state_s = SWEEP_OUT;
                    dwell_s = 8'd0;
                end else if (eff_s == EFF_OFF) begin
                    state_s = PARKED;
                    dwell_s = 8'd0;
                end else if (dwell_r == DWELL_M1) begin
                    state_s = SWEEP_OUT;
                    dwell_s = 8'd0;
                end else begin
                    dwell_s = dwell_r + 8'd1;
                end
            end
            default: begin
                state_s = PARKED;
                pos_s   = POS_ZERO;
                div_s   = 8'd0;
                dwell_s = 8'd0;
            end
        endcase
    end

    // Datapath registers: arm position, step divider, dwell timer, sweep count.
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            pos_r       <= POS_ZERO;
            div_r       <= 8'd0;
            dwell_r     <= 8'd0;
            count_r     <= 8'd0;
            hold_fast_r <= 1'b0;
        end else begin
            pos_r       <= pos_s;
            div_r       <= div_s;
            dwell_r     <= dwell_s;
            count_r     <= count_s;
            hold_fast_r <= hold_fast_s;
        end
    end

    // Outputs decoded straight from registers.
    always_comb begin
        led_arm     = LED_ONE << pos_r;
        parked      = (state_r == PARKED);
        sweep_count = count_r;
    end

endmodule
